// File: rtl/mem_pkg.sv
// Shared memory-request types and helpers for the request merge path.
package mem_pkg;

    localparam int MEM_DATA_W = 32;
    localparam int MEM_ADDR_W = 32;
    localparam int MEM_ID_W   = 1;

    typedef struct packed {
        logic                    read_enable;
        logic [MEM_DATA_W/8-1:0] write_enable;
        logic [MEM_ADDR_W-1:0]   addr;
        logic [MEM_DATA_W-1:0]   data;
        logic [MEM_ID_W-1:0]     id;
    } mem_req_t;

    // Merged id carries the source port index above the original id.
    function automatic int out_id_width(input int id_width, input int ports);
        return id_width + $clog2(ports);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at ptr, ptr moves past each served port.
module rr_arbiter #(
    parameter int PORTS = 2,
    localparam int SEL_WIDTH = $clog2(PORTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PORTS-1:0]     req,
    input  logic                 advance,
    output logic [PORTS-1:0]     grant,
    output logic [SEL_WIDTH-1:0] grant_idx,
    output logic                 any
);

    logic [SEL_WIDTH-1:0] ptr;
    logic [SEL_WIDTH-1:0] k;

    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        k         = '0;
        for (int i = 0; i < PORTS; i++) begin
            k = SEL_WIDTH'((int'(ptr) + i) % PORTS);
            if (!any && req[k]) begin
                any       = 1'b1;
                grant_idx = k;
            end
        end
        grant = '0;
        if (any) grant[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_idx == SEL_WIDTH'(PORTS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_merge.sv
// Merges several request streams into one registered output, tagging the id
// with the source port so responses can be routed back.
module mem_port_merge
    import mem_pkg::*;
#(
    parameter int PORTS      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [PORTS-1:0]                       in_valid,
    output logic [PORTS-1:0]                       in_ready,
    input  logic [PORTS-1:0]                       in_read_enable,
    input  logic [PORTS-1:0][DATA_WIDTH/8-1:0]     in_write_enable,
    input  logic [PORTS-1:0][ADDR_WIDTH-1:0]       in_addr,
    input  logic [PORTS-1:0][DATA_WIDTH-1:0]       in_data,
    input  logic [PORTS-1:0][ID_WIDTH-1:0]         in_id,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   out_read_enable,
    output logic [DATA_WIDTH/8-1:0]                out_write_enable,
    output logic [ADDR_WIDTH-1:0]                  out_addr,
    output logic [DATA_WIDTH-1:0]                  out_data,
    output logic [out_id_width(ID_WIDTH,PORTS)-1:0] out_id
);

    localparam int SEL_WIDTH = $clog2(PORTS);
    localparam int STRB      = DATA_WIDTH / 8;
    localparam int OID       = out_id_width(ID_WIDTH, PORTS);

    typedef struct packed {
        logic                  read_enable;
        logic [STRB-1:0]       write_enable;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [OID-1:0]        id;
    } req_t;

    logic [PORTS-1:0]     grant;
    logic [SEL_WIDTH-1:0] grant_idx;
    logic                 any_valid;
    logic                 slot_free;
    logic                 accept;
    req_t                 pick;
    req_t                 slot;

    rr_arbiter #(.PORTS(PORTS)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (in_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any_valid)
    );

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (!rst && slot_free && any_valid) ? grant : '0;
    assign accept    = |(in_ready & in_valid);

    always_comb begin
        pick              = '0;
        pick.read_enable  = in_read_enable[grant_idx];
        pick.write_enable = in_write_enable[grant_idx];
        pick.addr         = in_addr[grant_idx];
        pick.data         = in_data[grant_idx];
        pick.id           = {grant_idx, in_id[grant_idx]};
    end

    // Single output slot; refilled in the same edge it drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            slot      <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            slot      <= pick;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_read_enable  = slot.read_enable;
    assign out_write_enable = slot.write_enable;
    assign out_addr         = slot.addr;
    assign out_data         = slot.data;
    assign out_id           = slot.id;

endmodule

// File: tb/tb_mem_port_merge.sv
// Directed bench for mem_port_merge with a cycle-level reference model.
module tb_mem_port_merge;

    localparam int P   = 2;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int IW  = 1;
    localparam int SEL = 1;
    localparam int OIW = IW + SEL;

    logic                   clk;
    logic                   rst;
    logic [P-1:0]           in_valid;
    logic [P-1:0]           in_ready;
    logic [P-1:0]           in_read_enable;
    logic [P-1:0][DW/8-1:0] in_write_enable;
    logic [P-1:0][AW-1:0]   in_addr;
    logic [P-1:0][DW-1:0]   in_data;
    logic [P-1:0][IW-1:0]   in_id;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_read_enable;
    logic [DW/8-1:0]        out_write_enable;
    logic [AW-1:0]          out_addr;
    logic [DW-1:0]          out_data;
    logic [OIW-1:0]         out_id;

    int vectors = 0;
    int miscompares = 0;

    mem_port_merge #(
        .PORTS(P), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_read_enable   (in_read_enable),
        .in_write_enable  (in_write_enable),
        .in_addr          (in_addr),
        .in_data          (in_data),
        .in_id            (in_id),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_read_enable  (out_read_enable),
        .out_write_enable (out_write_enable),
        .out_addr         (out_addr),
        .out_data         (out_data),
        .out_id           (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference model state: what the output slot must hold.
    logic            m_valid = 1'b0;
    int              m_ptr = 0;
    logic            m_re = 1'b0;
    logic [DW/8-1:0] m_we = '0;
    logic [AW-1:0]   m_addr = '0;
    logic [DW-1:0]   m_data = '0;
    logic [OIW-1:0]  m_id = '0;

    logic            s_rst = 1'b1;
    logic            s_acc = 1'b0;
    logic            s_ordy = 1'b0;
    int              s_g = 0;
    logic            s_re = 1'b0;
    logic [DW/8-1:0] s_we = '0;
    logic [AW-1:0]   s_addr = '0;
    logic [DW-1:0]   s_data = '0;
    logic [OIW-1:0]  s_id = '0;

    always @(negedge clk) begin : cmp
        logic [P-1:0]   er;
        logic [SEL-1:0] gs;
        int             g;
        int             c;
        bit             found;
        found = 0;
        g     = 0;
        er    = '0;
        if (!rst) begin
            for (int i = 0; i < P; i++) begin
                c = (m_ptr + i) % P;
                if (!found && ((in_valid >> c) & 1) != 0) begin
                    found = 1;
                    g     = c;
                end
            end
        end
        if (found && (!m_valid || out_ready)) er = P'(1 << g);
        gs = SEL'(g);
        chk("in_ready", in_ready, er);
        chk("out_valid", out_valid, m_valid);
        chk("payload",
            {out_read_enable, out_write_enable, out_addr, out_data, out_id},
            {m_re, m_we, m_addr, m_data, m_id});
        s_rst  <= rst;
        s_acc  <= (er != '0);
        s_ordy <= out_ready;
        s_g    <= g;
        s_re   <= in_read_enable[gs];
        s_we   <= in_write_enable[gs];
        s_addr <= in_addr[gs];
        s_data <= in_data[gs];
        s_id   <= {gs, in_id[gs]};
    end

    always @(posedge clk) begin
        if (s_rst) begin
            m_valid <= 1'b0;
            m_ptr   <= 0;
            m_re    <= 1'b0;
            m_we    <= '0;
            m_addr  <= '0;
            m_data  <= '0;
            m_id    <= '0;
        end else if (s_acc) begin
            m_valid <= 1'b1;
            m_ptr   <= (s_g + 1) % P;
            m_re    <= s_re;
            m_we    <= s_we;
            m_addr  <= s_addr;
            m_data  <= s_data;
            m_id    <= s_id;
        end else if (s_ordy) begin
            m_valid <= 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        in_valid        = '0;
        in_read_enable  = '0;
        in_write_enable = '0;
        in_addr         = '0;
        in_data         = '0;
        in_id           = '0;
        out_ready       = 1'b1;

        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_valid", out_valid, 1'b0);
            chk("rst_ready", in_ready, 2'b00);
        end
        rst = 1'b0;
        step();
        chk("post_rst_valid", out_valid, 1'b0);

        in_addr[0] = 32'h100;
        in_data[0] = 32'hDEADBEEF;
        in_write_enable[0] = 4'hF;
        in_id[0] = 1'b1;
        in_valid = 2'b01;
        step();
        in_valid = 2'b00;
        chk("p0_valid", out_valid, 1'b1);
        chk("p0_addr", out_addr, 32'h100);
        chk("p0_data", out_data, 32'hDEADBEEF);
        chk("p0_we", out_write_enable, 4'hF);
        chk("p0_id", out_id, 2'b01);
        step();

        in_addr[1] = 32'h200;
        in_data[1] = 32'h12345678;
        in_write_enable[1] = 4'h3;
        in_id[1] = 1'b0;
        in_valid = 2'b10;
        step();
        in_valid = 2'b00;
        chk("p1_id", out_id, 2'b10);
        chk("p1_addr", out_addr, 32'h200);
        step();

        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("alt_valid", out_valid, 1'b1);
            chk("alt_id", out_id, (k % 2 == 0) ? 2'b01 : 2'b10);
        end

        step();
        out_ready = 1'b0;
        chk("stall_first", out_id, 2'b01);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_id", out_id, 2'b01);
            chk("stall_addr", out_addr, 32'h100);
            chk("stall_ready", in_ready, 2'b00);
        end
        out_ready = 1'b1;
        step();
        chk("resume_id", out_id, 2'b10);
        in_valid = 2'b00;
        step();
        step();

        in_read_enable = 2'b10;
        in_write_enable[1] = 4'h0;
        in_addr[1] = 32'h2000;
        in_valid = 2'b10;
        step();
        in_valid = 2'b00;
        chk("rd_re", out_read_enable, 1'b1);
        chk("rd_we", out_write_enable, 4'h0);
        chk("rd_addr", out_addr, 32'h2000);
        in_read_enable = 2'b00;
        step();

        in_valid = 2'b01;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("solo_valid", out_valid, 1'b1);
            chk("solo_id", out_id, 2'b01);
        end

        rst = 1'b1;
        in_valid = 2'b11;
        step();
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_ready", in_ready, 2'b00);
        rst = 1'b0;
        step();
        chk("after_rst_id", out_id, 2'b01);
        in_valid = 2'b00;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
